// File: rtl/hc_mmio_rd_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module : hc_mmio_rd_responder_pkg
// Brief  : CCI-P MMIO types, HardCloud CSR map and read-decode helper.
// Rev    : 1.0  initial release
// ============================================================================
package hc_mmio_rd_responder_pkg;

    typedef struct packed {
        logic [15:0] address;   // DWORD address
        logic [1:0]  length;
        logic        rsvd;
        logic [8:0]  tid;
    } t_ccip_c0_ReqMmioHdr;

    typedef struct packed {
        t_ccip_c0_ReqMmioHdr hdr;
        logic [511:0]        data;
        logic                rspValid;
        logic                mmioRdValid;
        logic                mmioWrValid;
    } t_if_ccip_c0_Rx;

    typedef struct packed {
        logic [8:0] tid;
    } t_ccip_c2_RspMmioHdr;

    typedef struct packed {
        t_ccip_c2_RspMmioHdr hdr;
        logic                mmioRdValid;
        logic [63:0]         data;
    } t_if_ccip_c2_Tx;

    typedef struct packed {
        logic [29:0] rsvd;
        logic        soft_reset;
        logic        start;
    } t_hc_control;

    typedef struct packed {
        logic [63:0] address;
        logic [31:0] size;
    } t_hc_buffer;

    typedef struct packed {
        logic [8:0]  tid;
        logic [15:0] address;
        logic [1:0]  length;
        logic        valid;
    } t_hc_mmio_rd_req;

    typedef struct packed {
        logic [63:0] dsm_base;
        t_hc_control control;
        logic [31:0] afu_status;
    } t_hc_mmio_rd_snap;

    // Byte addresses of the CSR map
    localparam logic [15:0] HC_DFH_ADDR     = 16'h000;
    localparam logic [15:0] HC_AFU_ID_L     = 16'h008;
    localparam logic [15:0] HC_AFU_ID_H     = 16'h010;
    localparam logic [15:0] HC_DSM_BASE     = 16'h110;
    localparam logic [15:0] HC_CONTROL      = 16'h118;
    localparam logic [15:0] HC_BUF_BASE     = 16'h120;
    localparam logic [15:0] HC_BUF_STRIDE   = 16'h010;
    localparam logic [15:0] HC_BUF_SIZE_OFS = 16'h008;
    localparam logic [15:0] HC_AFU_STATUS   = 16'h140;
    localparam logic [15:0] HC_PERF_CYCLES  = 16'h150;
    localparam logic [15:0] HC_PERF_RDCNT   = 16'h158;

    // AFU feature header: type AFU, end-of-list set at bit 40
    localparam logic [63:0] HC_DFH = {4'h1, 19'h0, 1'b1, 24'h0, 16'h0};

    // Fixed (non-buffer) 64-bit words at an 8-byte aligned byte address
    function automatic logic [63:0] hc_mmio_rd_decode(
        input logic [15:0]      addr,
        input t_hc_mmio_rd_snap snap,
        input logic [63:0]      afu_id_l,
        input logic [63:0]      afu_id_h
    );
        logic [63:0] word;
        word = '0;
        case (addr)
            HC_DFH_ADDR:   word = HC_DFH;
            HC_AFU_ID_L:   word = afu_id_l;
            HC_AFU_ID_H:   word = afu_id_h;
            HC_DSM_BASE:   word = {32'h0, snap.dsm_base[31:0]};
            HC_CONTROL:    word = {32'h0, snap.control};
            HC_AFU_STATUS: word = {32'h0, snap.afu_status};
            default:       word = '0;
        endcase
        return word;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hc_mmio_rd_mux.sv
`default_nettype none
// ============================================================================
// Module : hc_mmio_rd_mux
// Brief  : Combinational S2 address decode and 4B/8B data select.
//          HC_MMIO_RD_PERF_EN adds the performance counter words.
// Rev    : 1.0  initial release
// ============================================================================
module hc_mmio_rd_mux
    import hc_mmio_rd_responder_pkg::*;
#(
    parameter int          HC_BUFFER_SIZE = 2,
    parameter logic [63:0] AFU_ID_L       = 64'h0,
    parameter logic [63:0] AFU_ID_H       = 64'h0
) (
    input  logic [15:0]                     i_address,
    input  logic [1:0]                      i_length,
    input  t_hc_mmio_rd_snap                i_snap,
`ifdef HC_MMIO_RD_PERF_EN
    input  logic [63:0]                     i_perf_cycles,
    input  logic [31:0]                     i_perf_rdcnt,
`endif
    input  t_hc_buffer [HC_BUFFER_SIZE-1:0] i_buffers,
    output logic [63:0]                     o_data
);

    logic        w_in_range;
    logic        w_hi;
    logic [15:0] w_word_addr;
    logic [63:0] w_word;

    // Byte address = DWORD address << 2; anything at or above 64 KiB is unmapped
    assign w_in_range  = (i_address[15:14] == 2'b00);
    assign w_hi        = i_address[0];
    assign w_word_addr = {i_address[13:1], 3'b000};

    always_comb begin
        w_word = '0;
        o_data = '0;
        if (w_in_range) begin
            w_word = hc_mmio_rd_decode(w_word_addr, i_snap, AFU_ID_L, AFU_ID_H);
            for (int i = 0; i < HC_BUFFER_SIZE; i++) begin
                if (w_word_addr == HC_BUF_BASE + 16'(i) * HC_BUF_STRIDE)
                    w_word = i_buffers[i].address;
                if (w_word_addr == HC_BUF_BASE + 16'(i) * HC_BUF_STRIDE + HC_BUF_SIZE_OFS)
                    w_word = {32'h0, i_buffers[i].size};
            end
`ifdef HC_MMIO_RD_PERF_EN
            if (w_word_addr == HC_PERF_CYCLES)
                w_word = i_perf_cycles;
            if (w_word_addr == HC_PERF_RDCNT)
                w_word = {32'h0, i_perf_rdcnt};
`endif
        end
        case (i_length)
            2'd0: begin
                // DSM base upper half lives at 0x114 instead of the 0x110 word's top
                if (w_in_range && w_word_addr == HC_DSM_BASE && w_hi)
                    o_data = {32'h0, i_snap.dsm_base[63:32]};
                else if (w_hi)
                    o_data = {32'h0, w_word[63:32]};
                else
                    o_data = {32'h0, w_word[31:0]};
            end
            2'd1:    o_data = w_hi ? 64'h0 : w_word;
            default: o_data = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/hc_mmio_rd_responder.sv
`default_nettype none
// ============================================================================
// Module : hc_mmio_rd_responder
// Brief  : Two-stage CCI-P MMIO read responder (c0 request -> c2 completion)
//          for the HardCloud AFU CSR space. Macro HC_MMIO_RD_PERF_EN adds
//          cycle and read counters.
// Rev    : 1.0  initial release
// ============================================================================
module hc_mmio_rd_responder
    import hc_mmio_rd_responder_pkg::*;
#(
    parameter int          HC_BUFFER_SIZE = 2,
    parameter logic [63:0] AFU_ID_L       = 64'h0,
    parameter logic [63:0] AFU_ID_H       = 64'h0
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  t_if_ccip_c0_Rx                  cp2af_c0_rx,
    input  logic [63:0]                     csr_dsm_base,
    input  t_hc_control                     csr_control,
    input  t_hc_buffer [HC_BUFFER_SIZE-1:0] csr_buffers,
    input  logic [31:0]                     afu_status,
    output t_if_ccip_c2_Tx                  af2cp_c2_tx
);

    t_hc_mmio_rd_req                 req_q,  req_d;
    t_hc_mmio_rd_snap                snap_q, snap_d;
    t_hc_buffer [HC_BUFFER_SIZE-1:0] bufs_q, bufs_d;
    t_if_ccip_c2_Tx                  c2_q,   c2_d;
    logic                            w_accept;
    logic [63:0]                     w_mux_data;
    logic                            w_unused_c0;

    // Only reads are serviced; a write flagged alongside a read is ignored
    assign w_accept    = cp2af_c0_rx.mmioRdValid;
    assign w_unused_c0 = ^{cp2af_c0_rx.data, cp2af_c0_rx.rspValid,
                           cp2af_c0_rx.mmioWrValid, cp2af_c0_rx.hdr.rsvd};

    always_comb begin
        req_d.valid   = w_accept;
        req_d.tid     = cp2af_c0_rx.hdr.tid;
        req_d.address = cp2af_c0_rx.hdr.address;
        req_d.length  = cp2af_c0_rx.hdr.length;
        snap_d        = snap_q;
        bufs_d        = bufs_q;
        if (w_accept) begin
            snap_d.dsm_base   = csr_dsm_base;
            snap_d.control    = csr_control;
            snap_d.afu_status = afu_status;
            bufs_d            = csr_buffers;
        end
        c2_d             = '0;
        c2_d.mmioRdValid = req_q.valid;
        if (req_q.valid) begin
            c2_d.hdr.tid = req_q.tid;
            c2_d.data    = w_mux_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q  <= '0;
            snap_q <= '0;
            bufs_q <= '0;
            c2_q   <= '0;
        end else begin
            req_q  <= req_d;
            snap_q <= snap_d;
            bufs_q <= bufs_d;
            c2_q   <= c2_d;
        end
    end

`ifdef HC_MMIO_RD_PERF_EN
    logic [63:0] cycles_q,    cycles_d;
    logic [31:0] rdcnt_q,     rdcnt_d;
    logic [63:0] cyc_snap_q,  cyc_snap_d;
    logic [31:0] rd_snap_q,   rd_snap_d;

    // Snapshot takes the pre-increment count so a 0x158 read excludes itself
    always_comb begin
        cycles_d   = cycles_q + 64'd1;
        rdcnt_d    = rdcnt_q;
        cyc_snap_d = cyc_snap_q;
        rd_snap_d  = rd_snap_q;
        if (w_accept) begin
            if (rdcnt_q != 32'hFFFF_FFFF)
                rdcnt_d = rdcnt_q + 32'd1;
            cyc_snap_d = cycles_q;
            rd_snap_d  = rdcnt_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycles_q   <= '0;
            rdcnt_q    <= '0;
            cyc_snap_q <= '0;
            rd_snap_q  <= '0;
        end else begin
            cycles_q   <= cycles_d;
            rdcnt_q    <= rdcnt_d;
            cyc_snap_q <= cyc_snap_d;
            rd_snap_q  <= rd_snap_d;
        end
    end
`endif

    hc_mmio_rd_mux #(
        .HC_BUFFER_SIZE (HC_BUFFER_SIZE),
        .AFU_ID_L       (AFU_ID_L),
        .AFU_ID_H       (AFU_ID_H)
    ) u_mux (
        .i_address      (req_q.address),
        .i_length       (req_q.length),
        .i_snap         (snap_q),
`ifdef HC_MMIO_RD_PERF_EN
        .i_perf_cycles  (cyc_snap_q),
        .i_perf_rdcnt   (rd_snap_q),
`endif
        .i_buffers      (bufs_q),
        .o_data         (w_mux_data)
    );

    assign af2cp_c2_tx = c2_q;

endmodule
`default_nettype wire

// File: tb/tb_hc_mmio_rd_responder.sv
`default_nettype none
// ============================================================================
// Module : tb_hc_mmio_rd_responder
// Brief  : Directed plus randomized bench with a behavioural CSR-map model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_hc_mmio_rd_responder;
    import hc_mmio_rd_responder_pkg::*;

    localparam int          NBUF = 2;
    localparam logic [63:0] ID_L = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] ID_H = 64'hFEDC_BA98_7654_3210;
    localparam logic [63:0] DFH_EXP = 64'h1000_0100_0000_0000;

    logic                  clk;
    logic                  rst_n;
    t_if_ccip_c0_Rx        c0;
    logic [63:0]           dsm;
    t_hc_control           ctrl;
    t_hc_buffer [NBUF-1:0] bufs;
    logic [31:0]           status;
    t_if_ccip_c2_Tx        c2;

    hc_mmio_rd_responder #(
        .HC_BUFFER_SIZE (NBUF),
        .AFU_ID_L       (ID_L),
        .AFU_ID_H       (ID_H)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cp2af_c0_rx  (c0),
        .csr_dsm_base (dsm),
        .csr_control  (ctrl),
        .csr_buffers  (bufs),
        .afu_status   (status),
        .af2cp_c2_tx  (c2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [8:0]  tid;
        logic [63:0] data;
        bit          chk;
    } exp_t;

    exp_t        sb[$];
    int          cycle;
    int          n_vec;
    int          n_err;
    logic [31:0] rdcnt_model;
    logic [63:0] last_data;

    // Whole 64-bit word stored at an 8-byte aligned byte address
    function automatic logic [63:0] word_at(input int b);
        if (b == 'h000) return DFH_EXP;
        if (b == 'h008) return ID_L;
        if (b == 'h010) return ID_H;
        if (b == 'h110) return {32'h0, dsm[31:0]};
        if (b == 'h118) return {32'h0, ctrl};
        if (b == 'h140) return {32'h0, status};
`ifdef HC_MMIO_RD_PERF_EN
        if (b == 'h158) return {32'h0, rdcnt_model};
`endif
        for (int i = 0; i < NBUF; i++) begin
            if (b == 'h120 + 16 * i) return bufs[i].address;
            if (b == 'h128 + 16 * i) return {32'h0, bufs[i].size};
        end
        return 64'h0;
    endfunction

    function automatic logic [63:0] model_rsp(input logic [15:0] dw, input logic [1:0] len);
        int          b;
        logic [63:0] w;
        b = int'({dw, 2'b00});
        w = word_at((b / 8) * 8);
        if (len == 2'd1) return dw[0] ? 64'h0 : w;
        if (len != 2'd0) return 64'h0;
        if (b == 'h114) return {32'h0, dsm[63:32]};
        return dw[0] ? {32'h0, w[63:32]} : {32'h0, w[31:0]};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        bit   e_v;
        exp_t e;
        @(posedge clk);
        #1;
        cycle++;
        e_v = (sb.size() > 0) && (sb[0].due == cycle);
        check("c2_valid", 64'(c2.mmioRdValid), 64'(e_v));
        if (e_v) begin
            e = sb.pop_front();
            if (c2.mmioRdValid === 1'b1) begin
                check("c2_tid", 64'(c2.hdr.tid), 64'(e.tid));
                if (e.chk) check("c2_data", c2.data, e.data);
                last_data = c2.data;
            end
        end
    endtask

    task automatic send(input logic [15:0] dw, input logic [1:0] len, input logic [8:0] t,
                        input bit rd = 1'b1, input bit wr = 1'b0, input bit chk = 1'b1);
        exp_t e;
        c0.hdr.address  = dw;
        c0.hdr.length   = len;
        c0.hdr.tid      = t;
        c0.mmioRdValid  = rd;
        c0.mmioWrValid  = wr;
        if (rd) begin
            e.due  = cycle + 2;
            e.tid  = t;
            e.data = model_rsp(dw, len);
            e.chk  = chk;
            sb.push_back(e);
            if (rdcnt_model != 32'hFFFF_FFFF) rdcnt_model++;
        end
        tick();
        c0.mmioRdValid = 1'b0;
        c0.mmioWrValid = 1'b0;
    endtask

    task automatic idle();
        c0.mmioRdValid = 1'b0;
        c0.mmioWrValid = 1'b0;
        tick();
    endtask

    logic [15:0] addr_tbl [23];
    logic [63:0] perf_a;
    logic [63:0] perf_exp;
    int          k1;
    int          k2;

    initial begin
        addr_tbl = '{16'h000, 16'h004, 16'h008, 16'h00C, 16'h010, 16'h018, 16'h020,
                     16'h110, 16'h114, 16'h118, 16'h11C, 16'h120, 16'h124, 16'h128,
                     16'h130, 16'h134, 16'h138, 16'h140, 16'h144, 16'h148, 16'h158,
                     16'h15C, 16'h7F8};
        cycle       = 0;
        n_vec       = 0;
        n_err       = 0;
        rdcnt_model = '0;
        last_data   = '0;
        c0          = '0;
        dsm         = 64'h1111_2222_3333_4444;
        ctrl        = t_hc_control'(32'h0000_0001);
        status      = 32'h0;
        bufs[0]     = '{address: 64'hA0A0_0000_0000_2000, size: 32'h100};
        bufs[1]     = '{address: 64'hB0B0_0000_0000_3000, size: 32'h200};
        rst_n       = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_valid", 64'(c2.mmioRdValid), 64'h0);
        check("rst_tid",   64'(c2.hdr.tid),     64'h0);
        check("rst_data",  c2.data,             64'h0);
        rst_n = 1'b1;
        idle();

        // DFH read
        send(16'h0000, 2'd1, 9'h05);
        idle();
        check("dfh_type", 64'(last_data[63:60]), 64'h1);
        check("dfh_eol",  64'(last_data[40]),    64'h1);

        // Buffer 1 address, 8B then upper 4B
        bufs[1].address = 64'hDEAD_BEEF_0000_1000;
        send(16'h004C, 2'd1, 9'h07);
        idle();
        check("buf1_addr", last_data, 64'hDEAD_BEEF_0000_1000);
        send(16'h004D, 2'd0, 9'h08);
        idle();
        check("buf1_addr_hi", last_data, 64'h0000_0000_DEAD_BEEF);

        // Back-to-back, last one unmapped
        send(16'h0046, 2'd1, 9'h01);
        send(16'h0050, 2'd1, 9'h02);
        send(16'h01FE, 2'd1, 9'h03);
        idle();
        check("unmapped", last_data, 64'h0);

        // Status changes after the request is sampled
        status = 32'h0;
        send(16'h0050, 2'd1, 9'h04);
        status = 32'h1;
        idle();
        check("status_snapshot", last_data, 64'h0);

        // DSM halves, misaligned 8B, illegal lengths
        dsm = 64'hCAFE_F00D_1234_5678;
        send(16'h0045, 2'd0, 9'h10);
        idle();
        check("dsm_hi", last_data, 64'h0000_0000_CAFE_F00D);
        send(16'h0044, 2'd1, 9'h11);
        send(16'h0045, 2'd1, 9'h12);
        send(16'h0002, 2'd2, 9'h13);
        send(16'h0002, 2'd3, 9'h14);
        idle();

        // Write-only ignored; read+write serviced once
        send(16'h0000, 2'd1, 9'h20, 1'b0, 1'b1);
        idle();
        idle();
        send(16'h0002, 2'd1, 9'h21, 1'b1, 1'b1);
        idle();

        // Reset with a request in S1
        send(16'h0050, 2'd1, 9'h1A);
        rst_n = 1'b0;
        #1;
        check("rst_s1_valid", 64'(c2.mmioRdValid), 64'h0);
        sb.delete();
        rdcnt_model = '0;
        idle();
        idle();
        rst_n = 1'b1;
        idle();
        idle();
        idle();

        // Reset while c2 valid is high
        send(16'h0046, 2'd1, 9'h1B);
        idle();
        rst_n = 1'b0;
        #1;
        check("rst_c2_valid", 64'(c2.mmioRdValid), 64'h0);
        check("rst_c2_data",  c2.data,             64'h0);
        sb.delete();
        rdcnt_model = '0;
        idle();
        rst_n = 1'b1;
        idle();

        // Read counter after five reads
        for (int i = 0; i < 5; i++) send(16'h0000, 2'd1, 9'(i));
        send(16'h0056, 2'd1, 9'h30);
        idle();
`ifdef HC_MMIO_RD_PERF_EN
        perf_exp = 64'd5;
`else
        perf_exp = 64'd0;
`endif
        check("perf_rdcnt", last_data, perf_exp);

        // Cycle counter: delta between two reads equals elapsed cycles
`ifdef HC_MMIO_RD_PERF_EN
        k1 = cycle;
        send(16'h0054, 2'd1, 9'h31, 1'b1, 1'b0, 1'b0);
        idle();
        perf_a = last_data;
        repeat (4) idle();
        k2 = cycle;
        send(16'h0054, 2'd1, 9'h32, 1'b1, 1'b0, 1'b0);
        idle();
        check("perf_cycles_delta", last_data - perf_a, 64'(k2 - k1));
`else
        send(16'h0054, 2'd1, 9'h31);
        idle();
        check("perf_cycles_off", last_data, 64'h0);
`endif

        // Randomized traffic against the model
        for (int n = 0; n < 300; n++) begin
            logic [15:0] dw;
            if ($urandom_range(0, 3) == 0) dsm = {$urandom(), $urandom()};
            if ($urandom_range(0, 3) == 0) ctrl = t_hc_control'($urandom());
            if ($urandom_range(0, 2) == 0) status = $urandom();
            if ($urandom_range(0, 3) == 0) begin
                bufs[$urandom_range(0, NBUF - 1)] = '{address: {$urandom(), $urandom()},
                                                      size: $urandom()};
            end
            if ($urandom_range(0, 4) == 0) begin
                dw = 16'($urandom_range(0, 65535));
                if (dw == 16'h0054 || dw == 16'h0055) dw = 16'h0056;
            end else begin
                dw = addr_tbl[$urandom_range(0, 22)] >> 2;
            end
            if ($urandom_range(0, 3) == 0)
                send(dw, 2'($urandom_range(0, 3)), 9'($urandom()), 1'b0, 1'($urandom_range(0, 1)));
            else
                send(dw, 2'($urandom_range(0, 1) + (($urandom_range(0, 9) == 0) ? 2 : 0)),
                     9'($urandom()), 1'b1, ($urandom_range(0, 9) == 0));
        end
        idle();
        idle();
        idle();
        check("drain", 64'(sb.size()), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
